// File: rtl/trace_bp_pkg.sv
// Shared types and helpers for the multi-channel trace backpressure arbiter.
package trace_bp_pkg;

  typedef enum logic {
    REC_SAMPLE = 1'b0,
    REC_COUNT  = 1'b1
  } rec_type_e;

  // Channel-id field width; a single channel still carries a 1-bit id.
  function automatic int id_w_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trace_bp_arbiter_if.sv
// Bundle of the per-channel sample inputs and the merged valid/ready FIFO side.
interface trace_bp_arbiter_if #(
  parameter int channels_p     = 2,
  parameter int sample_width_p = 4,
  parameter int rec_w_p        = 1 + trace_bp_pkg::id_w_f(channels_p) + sample_width_p
);
  logic [channels_p-1:0]                sample_valid;
  logic [channels_p*sample_width_p-1:0] sample_data;
  logic [rec_w_p-1:0]                   fifo_data;
  logic                                 fifo_valid;
  logic                                 fifo_ready;

  modport master (
    output sample_valid, sample_data, fifo_ready,
    input  fifo_data, fifo_valid
  );

  modport slave (
    input  sample_valid, sample_data, fifo_ready,
    output fifo_data, fifo_valid
  );
endinterface

// File: rtl/trace_bp_arbiter_rr.sv
// Round-robin arbiter: one-hot grant from requests and a rotating priority pointer.
module trace_rr_arbiter #(
  parameter int n_p    = 2,
  parameter int id_w_p = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [n_p-1:0]    req,
  input  logic              grant_en,
  output logic [n_p-1:0]    grant,
  output logic [id_w_p-1:0] grant_idx
);
  logic [id_w_p-1:0] ptr_reg;

  // Scan priority slots ptr, ptr+1, ... and take the first requester.
  always_comb begin : p_pick
    logic found;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < n_p; i++) begin
      for (int c = 0; c < n_p; c++) begin
        if (!found && req[c] &&
            ((int'(ptr_reg) + i == c) || (int'(ptr_reg) + i == c + n_p))) begin
          found     = 1'b1;
          grant[c]  = 1'b1;
          grant_idx = id_w_p'(c);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (grant_en) begin
      ptr_reg <= (int'(grant_idx) == n_p - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/trace_bp_arbiter.sv
// Merges channels_p trace sample streams into one valid/ready record stream with drop counting.
// Define TRACE_BP_SAT_EN to make drop counters saturate instead of wrapping.
module trace_bp_arbiter
  import trace_bp_pkg::*;
#(
  parameter int channels_p      = 2,
  parameter int sample_width_p  = 4,
  parameter int counter_width_p = 4
) (
  input logic               clk,
  input logic               rst,
  trace_bp_arbiter_if.slave bus
);
  localparam int ID_W = id_w_f(channels_p);
  localparam int SW   = sample_width_p;
  localparam int CW   = counter_width_p;

  typedef struct packed {
    rec_type_e         is_count;
    logic [ID_W-1:0]   chan_id;
    logic [SW-1:0]     payload;
  } rec_t;

  logic                     slot_free;
  logic                     grant_en;
  logic [channels_p-1:0]    req;
  logic [channels_p-1:0]    grant;
  logic [channels_p-1:0]    dirty;
  logic [ID_W-1:0]          grant_idx;
  logic [CW-1:0]            drop_cnt_reg [channels_p];
  logic [channels_p*CW-1:0] cnt_inc;
  rec_t                     rec_next;
  rec_t                     rec_reg;
  logic                     valid_reg;

  assign slot_free = !valid_reg || bus.fifo_ready;
  assign grant_en  = |req;

  generate
    for (genvar gi = 0; gi < channels_p; gi++) begin : g_chan
      assign dirty[gi] = (drop_cnt_reg[gi] != '0);
      assign req[gi]   = slot_free && (bus.sample_valid[gi] || dirty[gi]);
`ifdef TRACE_BP_SAT_EN
      assign cnt_inc[gi*CW +: CW] = (&drop_cnt_reg[gi]) ? drop_cnt_reg[gi]
                                                          : drop_cnt_reg[gi] + 1'b1;
`else
      assign cnt_inc[gi*CW +: CW] = drop_cnt_reg[gi] + 1'b1;
`endif
    end
  endgenerate

  trace_rr_arbiter #(
    .n_p    (channels_p),
    .id_w_p (ID_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant_en  (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A dirty winner must flush its count before any further sample from it.
  always_comb begin
    rec_next = '0;
    for (int c = 0; c < channels_p; c++) begin
      if (grant[c]) begin
        rec_next.chan_id = ID_W'(c);
        if (dirty[c]) begin
          rec_next.is_count = REC_COUNT;
          rec_next.payload  = SW'(drop_cnt_reg[c]);
        end else begin
          rec_next.is_count = REC_SAMPLE;
          rec_next.payload  = bus.sample_data[c*SW +: SW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < channels_p; c++) begin
        drop_cnt_reg[c] <= '0;
      end
    end else begin
      for (int c = 0; c < channels_p; c++) begin
        if (grant[c] && dirty[c]) begin
          drop_cnt_reg[c] <= bus.sample_valid[c] ? CW'(1) : '0;
        end else if (!grant[c] && bus.sample_valid[c]) begin
          drop_cnt_reg[c] <= cnt_inc[c*CW +: CW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      rec_reg   <= '0;
    end else if (grant_en) begin
      valid_reg <= 1'b1;
      rec_reg   <= rec_next;
    end else if (bus.fifo_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.fifo_data  = rec_reg;
  assign bus.fifo_valid = valid_reg;

endmodule

// File: tb/tb_trace_bp_arbiter.sv
// Directed table-driven bench for trace_bp_arbiter (2 channels, 4-bit samples and counters).
module tb_trace_bp_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  trace_bp_arbiter_if #(.channels_p(2), .sample_width_p(4)) bus ();

  trace_bp_arbiter #(
    .channels_p      (2),
    .sample_width_p  (4),
    .counter_width_p (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst_before;
    logic [1:0] sv;
    logic [7:0] sd;
    logic       ready;
    logic       exp_valid;
    logic       chk_data;
    logic [5:0] exp_data;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

`ifdef TRACE_BP_SAT_EN
  localparam logic [5:0] HOLD_COUNT_REC = 6'h2F;
`else
  localparam logic [5:0] HOLD_COUNT_REC = 6'h24;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sv, input logic [7:0] sd, input logic ready);
    bus.sample_valid = sv;
    bus.sample_data  = sd;
    bus.fifo_ready   = ready;
  endtask

  task automatic step(input logic [1:0] sv, input logic [7:0] sd, input logic ready);
    drive(sv, sd, ready);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // {rst_before, sv, sd={d1,d0}, ready, exp_valid, chk_data, exp_data={is_count,id,payload}}
    vecs[0]  = '{1'b1, 2'b01, 8'h05, 1'b1, 1'b1, 1'b1, 6'h05};
    vecs[1]  = '{1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 6'h00};
    vecs[2]  = '{1'b0, 2'b01, 8'h06, 1'b1, 1'b1, 1'b1, 6'h06};
    vecs[3]  = '{1'b0, 2'b01, 8'h07, 1'b0, 1'b1, 1'b1, 6'h06};
    vecs[4]  = '{1'b0, 2'b01, 8'h08, 1'b0, 1'b1, 1'b1, 6'h06};
    vecs[5]  = '{1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1, 6'h22};
    vecs[6]  = '{1'b0, 2'b01, 8'h09, 1'b1, 1'b1, 1'b1, 6'h09};
    vecs[7]  = '{1'b1, 2'b11, 8'hA3, 1'b1, 1'b1, 1'b1, 6'h03};
    vecs[8]  = '{1'b0, 2'b11, 8'hA4, 1'b1, 1'b1, 1'b1, 6'h31};
    vecs[9]  = '{1'b0, 2'b11, 8'hA5, 1'b1, 1'b1, 1'b1, 6'h21};
    vecs[10] = '{1'b0, 2'b11, 8'hA6, 1'b1, 1'b1, 1'b1, 6'h32};
    vecs[11] = '{1'b0, 2'b11, 8'hA7, 1'b1, 1'b1, 1'b1, 6'h22};
    vecs[12] = '{1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1, 6'h32};
    vecs[13] = '{1'b0, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1, 6'h21};
    vecs[14] = '{1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 6'h00};

    drive(2'b00, 8'h00, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("reset valid", 32'(bus.fifo_valid), 32'd0);
    check("reset data", 32'(bus.fifo_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst_before) do_reset();
      step(vecs[i].sv, vecs[i].sd, vecs[i].ready);
      check($sformatf("vec%0d valid", i), 32'(bus.fifo_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d data", i), 32'(bus.fifo_data), 32'(vecs[i].exp_data));
      $display("vec %0d: sv=%b sd=%h ready=%b -> valid=%b data=%h", i,
               vecs[i].sv, vecs[i].sd, vecs[i].ready, bus.fifo_valid, bus.fifo_data);
    end

    // Long stall: 20 drops on ch0 while the held record stays put.
    do_reset();
    step(2'b01, 8'h01, 1'b1);
    check("stall load", 32'(bus.fifo_data), 32'h01);
    for (int i = 0; i < 20; i++) begin
      step(2'b01, 8'h0C, 1'b0);
      check($sformatf("stall hold%0d", i), 32'({bus.fifo_valid, bus.fifo_data}), 32'h41);
    end
    step(2'b00, 8'h00, 1'b1);
    check("stall count valid", 32'(bus.fifo_valid), 32'd1);
    check("stall count rec", 32'(bus.fifo_data), 32'(HOLD_COUNT_REC));
    $display("stall: count record data=%h", bus.fifo_data);
    step(2'b00, 8'h00, 1'b1);
    check("stall drain", 32'(bus.fifo_valid), 32'd0);

    // Mid-cycle reset with a held record and ch1 drop count of 3.
    do_reset();
    step(2'b01, 8'h02, 1'b1);
    check("rst pre load", 32'(bus.fifo_data), 32'h02);
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 8'h30, 1'b0);
      check($sformatf("rst pre hold%0d", i), 32'({bus.fifo_valid, bus.fifo_data}), 32'h42);
    end
    #3 rst = 1'b1;
    #1;
    check("async rst valid", 32'(bus.fifo_valid), 32'd0);
    check("async rst data", 32'(bus.fifo_data), 32'd0);
    $display("async reset: valid=%b data=%h", bus.fifo_valid, bus.fifo_data);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'b10, 8'h70, 1'b1);
    check("post rst valid", 32'(bus.fifo_valid), 32'd1);
    check("post rst sample", 32'(bus.fifo_data), 32'h17);
    $display("post reset: valid=%b data=%h", bus.fifo_valid, bus.fifo_data);
    step(2'b00, 8'h00, 1'b1);
    check("post rst no count", 32'(bus.fifo_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
